// File: rtl/fft_pkg.sv
// Shared FFT helpers: stage count, quarter-wave cosine ROM contents and the
// address/sign fold that rebuilds full-wave cos/sin from that quarter wave.
package fft_pkg;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } twiddle_t;

  typedef struct packed {
    logic [31:0] addr_c;
    logic [31:0] addr_s;
    logic        neg_c;
    logic        neg_s;
  } fold_t;

  // Twiddle multipliers needed by a radix-2 single-path FFT of length n.
  function automatic int fft_stages(input int n);
    return $clog2(n) - 1;
  endfunction

  // Entry j of round(cos(2*pi*j/n) * (2^(w-1)-1)); int'() rounds to nearest.
  function automatic int twiddle_quarter_rom(input int n, input int w, input int j);
    real pi_v;
    real amp;
    pi_v = 3.14159265358979323846;
    amp  = real'((1 << (w - 1)) - 1);
    return int'($cos(2.0 * pi_v * real'(j) / real'(n)) * amp);
  endfunction

  // Forward-direction fold for index i < n/2: cos is C[addr_c], sin is C[addr_s].
  function automatic fold_t twiddle_fold(input int i, input int n);
    fold_t f;
    int    q;
    q = n / 4;
    if (i <= q) begin
      f.addr_c = i;
      f.neg_c  = 1'b0;
      f.addr_s = q - i;
    end else begin
      f.addr_c = n / 2 - i;
      f.neg_c  = 1'b1;
      f.addr_s = i - q;
    end
    f.neg_s = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Quarter-wave cosine ROM with PORTS registered cos/sin read pairs; sign is
// applied on the read so the registered value is the final signed twiddle.
module twiddle_qrom
  import fft_pkg::*;
#(
  parameter int N     = 16,
  parameter int W     = 16,
  parameter int AW    = 3,
  parameter int PORTS = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [PORTS-1:0][AW-1:0]  addr_c,
  input  logic [PORTS-1:0][AW-1:0]  addr_s,
  input  logic [PORTS-1:0]          neg_c,
  input  logic [PORTS-1:0]          neg_s,
  output logic [PORTS-1:0][W-1:0]   rd_c,
  output logic [PORTS-1:0][W-1:0]   rd_s
);

  localparam int Q = N / 4;

  // Sized to the full address space so every address decodes; entries past Q are never selected.
  logic signed [W-1:0] rom [2**AW];

  for (genvar j = 0; j < 2**AW; j++) begin : g_rom
    assign rom[j] = (j <= Q) ? W'(twiddle_quarter_rom(N, W, j)) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_c <= '0;
      rd_s <= '0;
    end else if (en) begin
      for (int p = 0; p < PORTS; p++) begin
        rd_c[p] <= neg_c[p] ? -rom[addr_c[p]] : rom[addr_c[p]];
        rd_s[p] <= neg_s[p] ? -rom[addr_s[p]] : rom[addr_s[p]];
      end
    end
  end

endmodule

// File: rtl/twiddle_seq.sv
// Per-stage twiddle sequencer: owns the sample counter, folds each stage index onto a
// quarter-wave ROM, 2-cycle latency; a stalled output freezes the whole pipeline.
module twiddle_seq
  import fft_pkg::*;
#(
  parameter int FFT_SIZE = 16,
  parameter int TW_WIDTH = 16,
  localparam int STAGES  = fft_stages(FFT_SIZE)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              sof,
  input  logic                              inverse,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic [STAGES-1:0][TW_WIDTH-1:0]   tw_cos,
  output logic [STAGES-1:0][TW_WIDTH-1:0]   tw_sin
);

  localparam int L  = $clog2(FFT_SIZE);
  localparam int AW = L - 1;

  logic                       en;
  logic                       accept;
  logic [L-1:0]               cnt;
  logic [L-1:0]               k;
  logic                       inv_lat;
  logic                       inv_cur;
  logic [STAGES-1:0][AW-1:0]  ac_d, as_d, ac_q, as_q;
  logic [STAGES-1:0]          nc_d, ns_d, nc_q, ns_q;
  logic                       p1_vld;
  logic                       p1_last;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;
  assign k        = sof ? '0 : cnt;
  assign inv_cur  = sof ? inverse : inv_lat;

  // Stage s only sees the low L-1-s counter bits, scaled up so every index stays below N/2.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [AW-1:0] idx;
    fold_t         f;
    assign idx     = AW'(k << s);
    assign f       = twiddle_fold(int'(idx), FFT_SIZE);
    assign ac_d[s] = AW'(f.addr_c);
    assign as_d[s] = AW'(f.addr_s);
    assign nc_d[s] = f.neg_c;
    assign ns_d[s] = f.neg_s ^ inv_cur;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      inv_lat <= 1'b0;
    end else if (accept) begin
      cnt <= k + 1'b1;
      if (sof) inv_lat <= inverse;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_vld  <= 1'b0;
      p1_last <= 1'b0;
      ac_q    <= '0;
      as_q    <= '0;
      nc_q    <= '0;
      ns_q    <= '0;
    end else if (en) begin
      p1_vld  <= accept;
      p1_last <= accept && (k == L'(FFT_SIZE - 1));
      ac_q    <= ac_d;
      as_q    <= as_d;
      nc_q    <= nc_d;
      ns_q    <= ns_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (en) begin
      out_valid <= p1_vld;
      out_last  <= p1_last;
    end
  end

  // Bubbles leave the ROM registers untouched, so idle outputs stay at their last value.
  twiddle_qrom #(
    .N     (FFT_SIZE),
    .W     (TW_WIDTH),
    .AW    (AW),
    .PORTS (STAGES)
  ) u_qrom (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en && p1_vld),
    .addr_c (ac_q),
    .addr_s (as_q),
    .neg_c  (nc_q),
    .neg_s  (ns_q),
    .rd_c   (tw_cos),
    .rd_s   (tw_sin)
  );

endmodule

// File: tb/tb_twiddle_seq.sv
// Scoreboard bench for twiddle_seq: a bench-side counter/inverse model queues expected
// sample indices on accept; outputs are compared against full-wave cos/sin on handshake.
module tb_twiddle_seq;

  localparam int N  = 16;
  localparam int W  = 16;
  localparam int L  = $clog2(N);
  localparam int ST = L - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sof = 1'b0;
  logic inverse = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_last;
  logic [ST-1:0][W-1:0] tw_cos, tw_sin;

  always #5 clk = ~clk;

  twiddle_seq #(.FFT_SIZE(N), .TW_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sof       (sof),
    .inverse   (inverse),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .tw_cos    (tw_cos),
    .tw_sin    (tw_sin)
  );

  typedef struct {
    int k;
    bit inv;
    bit last;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   m_cnt = 0;
  bit   m_inv = 1'b0;
  int   n_out = 0;
  int   n_last = 0;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic real theta(input int k, input int s);
    int i;
    i = (k << s) % (N / 2);
    return 2.0 * 3.14159265358979323846 * real'(i) / real'(N);
  endfunction

  function automatic int exp_cos(input int k, input int s);
    return int'($cos(theta(k, s)) * real'((1 << (W - 1)) - 1));
  endfunction

  function automatic int exp_sin(input int k, input int s, input bit inv);
    int v;
    v = -int'($sin(theta(k, s)) * real'((1 << (W - 1)) - 1));
    return inv ? -v : v;
  endfunction

  task automatic compare_out(input exp_t e);
    for (int s = 0; s < ST; s++) begin
      check($sformatf("cos k%0d s%0d", e.k, s), $signed(tw_cos[s]), exp_cos(e.k, s));
      check($sformatf("sin k%0d s%0d i%0d", e.k, s, e.inv), $signed(tw_sin[s]), exp_sin(e.k, s, e.inv));
    end
    check($sformatf("last k%0d", e.k), out_last, e.last);
    if (e.k == 3 && !e.inv) begin
      check("lit k3 s0 cos", $signed(tw_cos[0]), 12539);
      check("lit k3 s0 sin", $signed(tw_sin[0]), -30273);
      check("lit k3 s1 cos", $signed(tw_cos[1]), -23170);
      check("lit k3 s1 sin", $signed(tw_sin[1]), -23170);
      check("lit k3 s2 cos", $signed(tw_cos[2]), 0);
      check("lit k3 s2 sin", $signed(tw_sin[2]), -32767);
    end
    if (e.k == 3 && e.inv) check("lit k3 s0 sin inv", $signed(tw_sin[0]), 30273);
    if (e.k == 0) begin
      for (int s = 0; s < ST; s++) begin
        check($sformatf("lit k0 s%0d cos", s), $signed(tw_cos[s]), 32767);
        check($sformatf("lit k0 s%0d sin", s), $signed(tw_sin[s]), 0);
      end
    end
    n_out++;
    if (out_last) n_last++;
  endtask

  task automatic cycle(input bit v, input bit s, input bit inv, input bit ordy);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    sof       = s;
    inverse   = inv;
    out_ready = ordy;
    #1;
    if (out_valid) begin
      if (sbq.size() == 0) begin
        check("out_valid with empty scoreboard", out_valid, 0);
      end else if (ordy) begin
        e = sbq.pop_front();
        compare_out(e);
      end else begin
        check("stall in_ready", in_ready, 0);
        check("hold cos0", $signed(tw_cos[0]), exp_cos(sbq[0].k, 0));
        check("hold sin0", $signed(tw_sin[0]), exp_sin(sbq[0].k, 0, sbq[0].inv));
        check("hold last", out_last, sbq[0].last);
      end
    end
    if (v && in_ready) begin
      e.k    = s ? 0 : m_cnt;
      e.inv  = s ? inv : m_inv;
      e.last = (e.k == N - 1);
      if (s) m_inv = inv;
      m_cnt = (e.k + 1) % N;
      sbq.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() > 0; i++) cycle(0, 0, 0, 1);
    check("drain empty", sbq.size(), 0);
  endtask

  // n accepts starting with sof; optional 5-cycle output stall before accept stall_at; sof again at resof.
  task automatic run_frame(input int n, input bit inv, input int stall_at, input int resof,
                           input int want_out, input int want_last);
    n_out  = 0;
    n_last = 0;
    for (int j = 0; j < n; j++) begin
      if (j == stall_at) for (int t = 0; t < 5; t++) cycle(1, 0, 0, 0);
      cycle(1, (j == 0) || (j == resof), (j == 0) ? inv : 1'b0, 1);
    end
    drain();
    check("frame outputs", n_out, want_out);
    check("frame lasts", n_last, want_last);
  endtask

  initial begin
    #12;
    check("reset out_valid", out_valid, 0);
    check("reset out_last", out_last, 0);
    check("reset in_ready", in_ready, 1);
    for (int s = 0; s < ST; s++) begin
      check($sformatf("reset cos s%0d", s), $signed(tw_cos[s]), 0);
      check($sformatf("reset sin s%0d", s), $signed(tw_sin[s]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 3; t++) cycle(0, 0, 0, 1);
    check("idle out_valid", out_valid, 0);
    check("idle cos0", $signed(tw_cos[0]), 0);
    check("idle in_ready", in_ready, 1);

    run_frame(16, 0, -1, -1, 16, 1);
    run_frame(16, 1, -1, -1, 16, 1);
    run_frame(16, 0, 7, -1, 16, 1);
    run_frame(20, 0, -1, -1, 20, 1);
    run_frame(26, 0, -1, 10, 26, 1);

    n_out = 0;
    for (int t = 0; t < 300; t++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
    drain();

    for (int j = 0; j < 6; j++) cycle(1, j == 0, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", out_valid, 0);
    check("async reset out_last", out_last, 0);
    check("async reset cos0", $signed(tw_cos[0]), 0);
    sbq.delete();
    m_cnt = 0;
    m_inv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_out = 0;
    for (int j = 0; j < 5; j++) cycle(1, 0, 0, 1);
    drain();
    check("post reset outputs", n_out, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/twiddle_seq.md
Name: twiddle_seq

Overview:
Parametrised successor to the per-stage twiddle lookup for the radix-2 single-path FFT.
- Owns the sample counter: derives every stage's twiddle index internally instead of taking indexes from the datapath.
- Stores only a quarter-wave cosine ROM and reconstructs full cos/sin by symmetry, so size stays small at large FFT_SIZE.
- Supports forward/inverse (conjugate) mode and a valid/ready handshake with back-pressure.
- Sits beside the butterfly pipeline and feeds all log2(N)-1 twiddle multipliers in lock-step with the sample stream.

Parameters:
FFT_SIZE, 16, transform length; power of two, >= 8
TW_WIDTH, 16, signed twiddle component width; unit magnitude = 2^(TW_WIDTH-1)-1

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
sof  in  1  start of frame; qualified by in_valid&&in_ready
inverse  in  1  1 = IFFT (conjugated twiddles); sampled with accepted sof
in_valid  in  1  one sample slot requested
in_ready  out  1  slot accepted this cycle
out_valid  out  1  tw_cos/tw_sin valid
out_ready  in  1  consumer accepts output
out_last  out  1  output belongs to sample index FFT_SIZE-1
tw_cos  out  STAGES x TW_WIDTH  signed cos per stage, stage 0 first; STAGES = log2(FFT_SIZE)-1
tw_sin  out  STAGES x TW_WIDTH  signed sin per stage

Behaviour:
- Reset (async, rst_n low): cnt=0, inverse latch=0, both pipeline valids=0, out_valid=0, out_last=0, tw_cos/tw_sin=0. in_ready is 1 after reset, since the pipeline is empty.
- Global enable: en = !out_valid || out_ready. in_ready = en. All pipeline registers update only when en=1. No bubble is inserted on stall; held outputs stay stable while out_valid && !out_ready.
- Accept: in_valid && in_ready.
- Counter k (log2 N bits):
  - On accept with sof, the sample uses k=0 and cnt becomes 1.
  - On accept without sof, the sample uses cnt, and cnt increments, wrapping N-1 -> 0.
  - sof mid-frame restarts at 0 with no error.
- Inverse mode:
  - On accept with sof, the inverse latch loads the inverse input, and the sample uses the new value.
  - Otherwise samples use the latched value.
- Stage index, for s = 0..STAGES-1: i_s = k[L-s-2:0] << s, with L = log2 N, so i_s < N/2.
- ROM: C[j] = round(cos(2*pi*j/N) * (2^(W-1)-1)), j = 0..N/4 (N/4+1 entries), built at elaboration.
- Fold, with Q = N/4:
  - i <= Q: cos = C[i], sin = -C[Q-i].
  - i > Q: cos = -C[N/2-i], sin = -C[i-Q].
  - When inverse=1, sin is negated.
  - Negation never overflows because |C| <= 2^(W-1)-1.
- Pipeline, latency 2 accepted cycles:
  - P1 registers the folded ROM addresses, negate flags, inverse, valid, and last = (k == N-1).
  - P2 registers the ROM reads with sign applied, and drives out_valid and out_last.
- Simultaneous in_valid and out_ready with a full pipeline gives full throughput, one twiddle set per cycle.
- Reset mid-frame discards in-flight data; the first post-reset sample without sof uses k=0.

Decomposition:
- fft_pkg:
  - clog2-derived helper constant.
  - Parametrisable ROM init function `twiddle_quarter_rom(N, W)`.
  - Fold function returning address plus negate flags.
  - Existing twiddle_t is unchanged; twiddle_seq uses explicit TW_WIDTH arrays.
- Sub-module `twiddle_qrom`: quarter-wave ROM with one read port per stage, registered output, and clock enable. It is instantiated once and supplies STAGES read ports.

Test Plan (FFT_SIZE=16, TW_WIDTH=16; C = 32767, 30273, 23170, 12539, 0):
- Reset then idle: all outputs 0, out_valid=0, in_ready=1. Assert rst_n low mid-stream: out_valid drops 0 immediately (async).
- sof + 16 back-to-back accepts, out_ready=1, inverse=0: k=3 output two cycles after its accept shows stage0 (12539, -30273), stage1 (-23170, -23170), stage2 (0, -32767). k=0 shows all stages (32767, 0). out_last is high only for k=15.
- Same frame with inverse=1 at sof: k=3 stage0 shows (12539, +30273). Inverse applies for the whole frame even if the inverse input drops after sof.
- Back-pressure: out_ready=0 for 5 cycles mid-frame. in_ready=0 and outputs hold. Resume with no lost or duplicated index; 16 outputs total.
- Wrap: 20 accepts without a second sof; accepts 17-20 reproduce k=0..3 values.
- sof at k=9: next output sequence restarts at k=0 values, and out_last occurs 16 accepts later.
